pipelined_reduce_gate: RTL and testbench
========================================

// Module: pipelined_reduce_gate
// PURPOSE
//  Parametrised, pipelined N-input reduction gate: reduces a WIDTH-bit vector to one bit with a
//  run-time selectable AND/OR/XOR op and optional output inversion (NAND/NOR/XNOR).
//  Balanced 2-input tree, one register per tree level, valid/ready flow control both sides.
//  Replaces the fixed-width combinational AND_4/OR_8/NAND_3 style gates in clocked datapaths;
//  keeps a saturating count of delivered results.
// PARAMETERS
//  WIDTH  8   input vector width, >=2; LEVELS = $clog2(WIDTH) pipeline stages
//  CNT_W  16  width of delivered-result counter
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_data    in   WIDTH  vector to reduce
//  in_mode    in   3      [1:0] op: 00 AND, 01 OR, 10 XOR, 11 reserved; [2] invert result
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  1      reduced (optionally inverted) bit
//  out_err    out  1      result came from reserved op
//  out_count  out  CNT_W  results delivered since reset/clear, saturating
//  cnt_clr    in   1      synchronous clear of out_count
// BEHAVIOUR
//  - Reset (async, active-high): all stage valids, stage data, out_data, out_err, out_count -> 0;
//    in-flight beats discarded; in_ready = 1 when reset is low and pipeline empty.
//  - Global enable en = !out_valid || out_ready; in_ready = en (combinational, no bubble collapse).
//  - When en=1 every stage advances one level; stage 1 captures tree level 1 on the accept edge
//    (in_valid && in_ready). en=0 freezes all stages, including valids, data, mode and err bits.
//  - Latency: beat accepted at edge n -> out_valid=1 after edge n+LEVELS-1 with no stall
//    (WIDTH=8: after edge n+2; WIDTH=2: after edge n). Throughput 1 beat/cycle.
//  - Leaf padding for non-power-of-2 WIDTH: unused leaves = identity (AND:1, OR/XOR:0), so e.g.
//    WIDTH=5 AND of 5'b11111 = 1.
//  - Op and invert bit travel with the beat through every stage; different modes may be in
//    flight simultaneously; each beat reduced only with its own mode.
//  - Inversion applied once, at the final stage, after the full reduction.
//  - Reserved op 11: out_data = 0 (invert ignored), out_err = 1 for that beat only.
//  - Bubbles (invalid stages) advance with en; their data is don't-care, out_data held stable
//    while out_valid=0 is not required.
//  - out_data/out_err stable while out_valid && !out_ready.
//  - out_count: +1 on each edge with out_valid && out_ready; holds at 2^CNT_W-1; cnt_clr has
//    priority over increment (clear and handshake on same edge -> 0).
// STRUCTURE
//  - Package basic_gates_pkg: localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_RSV=2'b11,
//    MODE_W=3, and function op_identity(op) returning the padding bit.
//  - One sub-module reduce_stage #(IN_W): one tree level (pairwise op, odd leaf passed through)
//    plus valid/mode/err/data register with enable; top instantiates LEVELS of them via generate,
//    final-stage inversion and counter in top.
// TESTING
//  - Reset: assert reset mid-stream with 3 beats in flight -> out_valid=0, out_count=0 at once;
//    first beat after release appears LEVELS cycles later.
//  - Modes, WIDTH=8, out_ready=1: 8'hFF AND->1, 8'hFE AND->0, 8'h00 OR->0, 8'h80 OR->1,
//    8'h07 XOR->1, mode 3'b100 on 8'hFF (NAND)->0, 3'b101 on 8'h00 (NOR)->1, 3'b110 on 8'h03->1.
//  - Back-to-back mixed modes every cycle -> one result per cycle, order and per-beat mode correct,
//    first result after edge n+2.
//  - Backpressure: out_ready=0 for 5 cycles with full pipeline -> in_ready=0, out_data stable,
//    no beat lost or duplicated after release.
//  - Reserved op 3'b011 and 3'b111 on 8'hFF -> out_data=0, out_err=1; next normal beat out_err=0.
//  - Counter: CNT_W=4, 20 handshakes -> out_count saturates at 15; cnt_clr on handshake edge -> 0.
//  - WIDTH=5 and WIDTH=2 builds: AND 5'b11111->1, OR 5'b10000->1, WIDTH=2 latency 1 edge.

Source files
------------

// File: rtl/pipelined_reduce_gate_pkg.sv
// rtl/pipelined_reduce_gate_pkg.sv - op codes, mode width and gate helper functions
package basic_gates_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam int         MODE_W = 3;

    // Padding bit that leaves the reduction unchanged for the given op
    function automatic logic op_identity(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    function automatic logic op_apply(input logic [1:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_reduce_gate_if.sv
// rtl/pipelined_reduce_gate_if.sv - input/output handshake and counter bundle
interface pipelined_reduce_gate_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    import basic_gates_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic [MODE_W-1:0]   in_mode;
    logic                out_valid;
    logic                out_ready;
    logic                out_data;
    logic                out_err;
    logic [CNT_W-1:0]    out_count;
    logic                cnt_clr;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_data, out_err, out_count
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_data, out_err, out_count
    );

endinterface

// File: rtl/pipelined_reduce_gate_reduce_stage.sv
// rtl/pipelined_reduce_gate_reduce_stage.sv - one tree level: pairwise op plus enabled register
module reduce_stage
    import basic_gates_pkg::*;
#(
    parameter  int IN_W  = 8,
    localparam int OUT_W = (IN_W + 1) / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              in_err,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_err
);

    logic [2*OUT_W-1:0] padded;
    logic [OUT_W-1:0]   level;

    // An odd leaf is paired with the op identity, i.e. passed through unchanged
    always_comb begin
        padded            = {(2*OUT_W){op_identity(in_mode[1:0])}};
        padded[IN_W-1:0]  = in_data;
        for (int i = 0; i < OUT_W; i++) begin
            level[i] = op_apply(in_mode[1:0], padded[2*i], padded[2*i+1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            out_err   <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= level;
            out_mode  <= in_mode;
            out_err   <= in_err;
        end
    end

endmodule

// File: rtl/pipelined_reduce_gate.sv
// rtl/pipelined_reduce_gate.sv - pipelined AND/OR/XOR reduction with optional inversion and result counter
module pipelined_reduce_gate
    import basic_gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipelined_reduce_gate_if.slave bus
);

    localparam int LEVELS = $clog2(WIDTH);

    function automatic int lvl_w(input int k);
        return (WIDTH + (1 << k) - 1) >> k;
    endfunction

    function automatic int lvl_off(input int k);
        int off = 0;
        for (int i = 0; i < k; i++) off += lvl_w(i);
        return off;
    endfunction

    localparam int TOT = lvl_off(LEVELS + 1);

    // All tree levels packed back to back; level k occupies lvl_w(k) bits at lvl_off(k)
    logic [TOT-1:0]                 data_bus;
    logic [LEVELS:0]                vld;
    logic [LEVELS:0]                err;
    logic [LEVELS:0][MODE_W-1:0]    mode;
    logic                           en;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    assign data_bus[WIDTH-1:0] = bus.in_data;
    assign vld[0]              = bus.in_valid;
    assign mode[0]             = bus.in_mode;
    assign err[0]              = (bus.in_mode[1:0] == OP_RSV);

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        reduce_stage #(.IN_W(lvl_w(k))) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .in_valid  (vld[k]),
            .in_data   (data_bus[lvl_off(k) +: lvl_w(k)]),
            .in_mode   (mode[k]),
            .in_err    (err[k]),
            .out_valid (vld[k+1]),
            .out_data  (data_bus[lvl_off(k+1) +: lvl_w(k+1)]),
            .out_mode  (mode[k+1]),
            .out_err   (err[k+1])
        );
    end

    assign bus.out_valid = vld[LEVELS];
    assign bus.out_err   = err[LEVELS];
    assign bus.out_data  = (mode[LEVELS][1:0] == OP_RSV) ? 1'b0
                                                          : (data_bus[TOT-1] ^ mode[LEVELS][2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_count <= '0;
        end else if (bus.cnt_clr) begin
            bus.out_count <= '0;
        end else if (bus.out_valid && bus.out_ready && (bus.out_count != '1)) begin
            bus.out_count <= bus.out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// tb/tb_pipelined_reduce_gate.sv - scoreboard bench for WIDTH=8/5/2 builds of pipelined_reduce_gate
module tb_pipelined_reduce_gate;

    localparam int ND = 3;

    typedef struct {
        logic [1:0] res;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid[ND];
    logic        in_ready[ND];
    logic [7:0]  in_data[ND];
    logic [2:0]  in_mode[ND];
    logic        out_valid[ND];
    logic        out_ready[ND];
    logic        out_data[ND];
    logic        out_err[ND];
    logic [15:0] out_count[ND];
    logic        cnt_clr[ND];

    int   rdy_mode[ND];
    logic clr_req[ND];
    exp_t exp_q[ND][$];
    int   cnt_model[ND];
    bit   seen[ND];
    int   last_stall[ND];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_reduce_gate_if #(.WIDTH(8), .CNT_W(4))  if0 ();
    pipelined_reduce_gate_if #(.WIDTH(5), .CNT_W(16)) if1 ();
    pipelined_reduce_gate_if #(.WIDTH(2), .CNT_W(16)) if2 ();

`define HOOK(J, IFN, W) \
    assign IFN.in_valid  = in_valid[J]; \
    assign IFN.in_data   = in_data[J][W-1:0]; \
    assign IFN.in_mode   = in_mode[J]; \
    assign IFN.out_ready = out_ready[J]; \
    assign IFN.cnt_clr   = cnt_clr[J]; \
    assign in_ready[J]   = IFN.in_ready; \
    assign out_valid[J]  = IFN.out_valid; \
    assign out_data[J]   = IFN.out_data; \
    assign out_err[J]    = IFN.out_err; \
    assign out_count[J]  = 16'(IFN.out_count);

    `HOOK(0, if0, 8)
    `HOOK(1, if1, 5)
    `HOOK(2, if2, 2)

    pipelined_reduce_gate #(.WIDTH(8), .CNT_W(4))  dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
    pipelined_reduce_gate #(.WIDTH(5), .CNT_W(16)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
    pipelined_reduce_gate #(.WIDTH(2), .CNT_W(16)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

    function automatic int width_of(input int j);
        return (j == 0) ? 8 : ((j == 1) ? 5 : 2);
    endfunction

    function automatic int levels_of(input int j);
        return (j == 2) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int j);
        return (j == 0) ? 15 : 65535;
    endfunction

    // Reference: {err, data} from the reduction rules applied to the whole vector
    function automatic logic [1:0] model(input int w, input logic [7:0] d, input logic [2:0] m);
        logic [7:0] mask;
        logic [7:0] v;
        logic       r;
        mask = 8'((1 << w) - 1);
        v    = d & mask;
        if (m[1:0] == 2'b11) return 2'b10;
        case (m[1:0])
            2'b00:   r = (v == mask);
            2'b01:   r = (v != 8'd0);
            default: r = ($countones(v) % 2) == 1;
        endcase
        return {1'b0, r ^ m[2]};
    endfunction

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, j, act, exp, cyc);
        end
    endtask

    task automatic send(input int j, input logic [7:0] d, input logic [2:0] m, input logic [1:0] res);
        int   budget = 0;
        exp_t e;
        @(negedge clk);
        in_valid[j] = 1'b1;
        in_data[j]  = d;
        in_mode[j]  = m;
        forever begin
            #1;
            if (in_ready[j]) break;
            if (++budget > 200) begin
                n_vec++;
                n_fail++;
                $display("FAIL accept_timeout dut%0d: in_ready stuck 0", j);
                in_valid[j] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.res = res;
        e.cyc = cyc;
        exp_q[j].push_back(e);
        @(posedge clk);
        #1;
        in_valid[j] = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        n_vec++;
        if (b >= 500) begin
            n_fail++;
            $display("FAIL drain_timeout: results still outstanding %0d", b);
        end
        @(negedge clk);
    endtask

    task automatic rand_run(input int j);
        logic [7:0] d;
        logic [2:0] m;
        for (int i = 0; i < 120; i++) begin
            d = 8'($urandom);
            m = 3'($urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(j, d, m, model(width_of(j), d, m));
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int j = 0; j < ND; j++) begin
            out_ready[j] = (rdy_mode[j] == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode[j] == 1);
            cnt_clr[j]   = clr_req[j] || (rdy_mode[j] == 0 && $urandom_range(0, 40) == 0);
        end
    end

    // Monitor: checks the head expectation whenever a result is presented
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < ND; j++) begin
                chk("out_count", j, 32'(out_count[j]), 32'(cnt_model[j]));
                if (cnt_clr[j]) cnt_model[j] = 0;
                else if (out_valid[j] && out_ready[j] && cnt_model[j] != cmax_of(j)) cnt_model[j]++;
                if (out_valid[j]) begin
                    if (exp_q[j].size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL spurious_result dut%0d: got %0b expected none", j, {out_err[j], out_data[j]});
                    end else begin
                        chk("result", j, 32'({out_err[j], out_data[j]}), 32'(exp_q[j][0].res));
                        if (!seen[j]) begin
                            seen[j] = 1'b1;
                            if (last_stall[j] < exp_q[j][0].cyc)
                                chk("latency", j, 32'(cyc - exp_q[j][0].cyc), 32'(levels_of(j)));
                        end
                        if (out_ready[j]) begin
                            void'(exp_q[j].pop_front());
                            seen[j] = 1'b0;
                        end else begin
                            last_stall[j] = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tdat[11];
        logic [2:0] tmod[11];
        logic [1:0] tres[11];
        logic [2:0] mix[6];
        int t0;
        tdat = '{8'hFF, 8'hFE, 8'h00, 8'h80, 8'h07, 8'hFF, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h01};
        tmod = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011, 3'b111, 3'b001};
        tres = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        mix  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        rst = 1'b1;
        for (int j = 0; j < ND; j++) begin
            in_valid[j] = 1'b0; in_data[j] = '0; in_mode[j] = '0;
            out_ready[j] = 1'b1; cnt_clr[j] = 1'b0; clr_req[j] = 1'b0;
            rdy_mode[j] = 1; cnt_model[j] = 0; seen[j] = 1'b0; last_stall[j] = -1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < ND; j++) begin
            chk("rst_out_valid", j, 32'(out_valid[j]), 0);
            chk("rst_out_data", j, 32'(out_data[j]), 0);
            chk("rst_out_err", j, 32'(out_err[j]), 0);
            chk("rst_out_count", j, 32'(out_count[j]), 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int j = 0; j < ND; j++) chk("idle_in_ready", j, 32'(in_ready[j]), 1);

        for (int i = 0; i < 11; i++) send(0, tdat[i], tmod[i], tres[i]);
        send(1, 8'h1F, 3'b000, 2'b01);
        send(1, 8'h10, 3'b001, 2'b01);
        send(1, 8'h0F, 3'b000, 2'b00);
        send(2, 8'h03, 3'b000, 2'b01);
        send(2, 8'h01, 3'b110, 2'b00);
        drain();

        send(0, 8'h5A, mix[0], model(8, 8'h5A, mix[0]));
        t0 = cyc;
        for (int i = 1; i < 12; i++) send(0, 8'(i * 37), mix[i % 6], model(8, 8'(i * 37), mix[i % 6]));
        chk("back_to_back_cycles", 0, 32'(cyc - t0), 11);
        drain();

        rdy_mode[0] = 2;
        @(negedge clk);
        send(0, 8'hFF, 3'b000, 2'b01);
        send(0, 8'h00, 3'b101, 2'b01);
        send(0, 8'h0E, 3'b010, 2'b01);
        fork
            send(0, 8'h55, 3'b010, model(8, 8'h55, 3'b010));
        join_none
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 0, 32'(in_ready[0]), 0);
            chk("bp_out_valid", 0, 32'(out_valid[0]), 1);
        end
        rdy_mode[0] = 1;
        wait fork;
        drain();
        chk("saturated_count", 0, 32'(out_count[0]), 15);

        clr_req[0] = 1'b1;
        send(0, 8'hFF, 3'b000, 2'b01);
        drain();
        clr_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("clr_on_handshake", 0, 32'(out_count[0]), 0);
        send(0, 8'h80, 3'b001, 2'b01);
        drain();
        chk("count_after_clr", 0, 32'(out_count[0]), 1);

        for (int j = 0; j < ND; j++) rdy_mode[j] = 0;
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        for (int j = 0; j < ND; j++) rdy_mode[j] = 1;
        drain();

        send(0, 8'h01, 3'b010, 2'b01);
        send(0, 8'h02, 3'b001, 2'b01);
        send(0, 8'h03, 3'b110, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 0, 32'(out_valid[0]), 0);
        chk("midrst_out_count", 0, 32'(out_count[0]), 0);
        for (int j = 0; j < ND; j++) begin
            exp_q[j].delete();
            cnt_model[j] = 0;
            seen[j] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(0, 8'hF0, 3'b101, 2'b00);
        send(2, 8'h02, 3'b010, 2'b01);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
